data_memory_unit: RTL and testbench

DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

---
 rtl/data_memory_unit.sv | 138 +++++++++++++
 tb/tb_data_memory_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Byte-addressed little-endian data RAM with sized, sign/zero-extended loads and sticky first-error capture.
// Define MEM_MISALIGN_CHECK_EN to treat misaligned half/word accesses as errors instead of aligning them down.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_memory_unit #(
  parameter int DATA_WIDTH      = `DATA_WIDTH,
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] memoryAddress,
  input  logic [DATA_WIDTH-1:0] memoryDataWrite,
  input  logic [1:0]            memoryLength,
  input  logic                  store,
  input  logic                  load,
  input  logic                  loadUnsigned,
  output logic [DATA_WIDTH-1:0] memoryDataRead,
  output logic                  memoryError,
  output logic [DATA_WIDTH-1:0] errorAddress
);

  localparam int LANE_W = DATA_WIDTH / 4;
  localparam int IDX_W  = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [DATA_WIDTH-3:0] DEPTH = (DATA_WIDTH-2)'(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_RSVD = 2'd2,
    LEN_WORD = 2'd3
  } len_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic [DATA_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  len_e                  len;
  logic [1:0]            eff_off;
  logic                  range_err, len_err, align_err, acc_err, access_err;
  logic                  do_store, do_load;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] wr_word;

  // Captured load word and its extraction controls.
  logic [DATA_WIDTH-1:0] rd_word;
  len_e                  cap_len;
  logic [1:0]            cap_off;
  logic                  cap_uns;
  logic [LANE_W-1:0]     rd_byte;
  logic [2*LANE_W-1:0]   rd_half;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    word_idx  = memoryAddress[DATA_WIDTH-1:2];
    mem_idx   = word_idx[IDX_W-1:0];
    len       = len_e'(memoryLength);
    range_err = (word_idx >= DEPTH);
    len_err   = (len == LEN_RSVD);
    align_err = 1'b0;
    eff_off   = memoryAddress[1:0];
    case (len)
      LEN_HALF: eff_off = {memoryAddress[1], 1'b0};
      LEN_WORD: eff_off = 2'b00;
      default:  ;
    endcase
`ifdef MEM_MISALIGN_CHECK_EN
    align_err = ((len == LEN_HALF) && memoryAddress[0]) ||
                ((len == LEN_WORD) && (memoryAddress[1:0] != 2'b00));
`endif
    acc_err    = range_err | len_err | align_err;
    do_store   = store && !acc_err;
    do_load    = load && !store;
    access_err = (load || store) && (acc_err || (load && store));
  end

  // Replicate the right-aligned store data across lanes; the lane enables pick the target bytes.
  always_comb begin
    wr_word = memoryDataWrite;
    lane_en = 4'b1111;
    case (len)
      LEN_BYTE: begin
        wr_word = {4{memoryDataWrite[LANE_W-1:0]}};
        lane_en = 4'b0001 << eff_off;
      end
      LEN_HALF: begin
        wr_word = {2{memoryDataWrite[2*LANE_W-1:0]}};
        lane_en = eff_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // NOTE: the RAM array has no reset so it can map onto block RAM; writes are gated by reset instead.
  always_ff @(posedge clk) begin
    if (reset && do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[mem_idx][i*LANE_W +: LANE_W] <= wr_word[i*LANE_W +: LANE_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_word      <= '0;
      cap_len      <= LEN_BYTE;
      cap_off      <= 2'b00;
      cap_uns      <= 1'b0;
      memoryError  <= 1'b0;
      errorAddress <= '0;
    end else begin
      if (do_load) begin
        rd_word <= acc_err ? '0 : mem[mem_idx];
        cap_len <= len;
        cap_off <= eff_off;
        cap_uns <= loadUnsigned;
      end
      if (access_err) begin
        memoryError <= 1'b1;
        if (!memoryError) errorAddress <= memoryAddress;
      end
    end
  end

  always_comb begin
    rd_byte        = rd_word[LANE_W*int'(cap_off) +: LANE_W];
    rd_half        = rd_word[2*LANE_W*int'(cap_off[1]) +: 2*LANE_W];
    memoryDataRead = rd_word;
    case (cap_len)
      LEN_BYTE: memoryDataRead = {{(DATA_WIDTH-LANE_W){~cap_uns & rd_byte[LANE_W-1]}}, rd_byte};
      LEN_HALF: memoryDataRead = {{(DATA_WIDTH-2*LANE_W){~cap_uns & rd_half[2*LANE_W-1]}}, rd_half};
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed, table-driven bench for data_memory_unit: extension, lane writes, hold, errors, reset.
module tb_data_memory_unit;

  localparam int DEPTH = 1024;
  localparam logic [1:0] LB = 2'd0, LH = 2'd1, LR = 2'd2, LW = 2'd3;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memoryAddress, memoryDataWrite, memoryDataRead, errorAddress;
  logic [1:0]  memoryLength;
  logic        store, load, loadUnsigned, memoryError;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        st;
    logic        ld;
    logic        uns;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_memory_unit #(.DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .memoryAddress  (memoryAddress),
    .memoryDataWrite(memoryDataWrite),
    .memoryLength   (memoryLength),
    .store          (store),
    .load           (load),
    .loadUnsigned   (loadUnsigned),
    .memoryDataRead (memoryDataRead),
    .memoryError    (memoryError),
    .errorAddress   (errorAddress)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic st, input logic ld, input logic uns,
                              input logic [1:0] len, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input logic exp_err);
    vec_t v;
    v.name = name; v.st = st; v.ld = ld; v.uns = uns; v.len = len;
    v.addr = addr; v.wdata = wdata; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    store           = v.st;
    load            = v.ld;
    loadUnsigned    = v.uns;
    memoryLength    = v.len;
    memoryAddress   = v.addr;
    memoryDataWrite = v.wdata;
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare, return at the next falling edge.
  task automatic apply(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check({v.name, " data"}, memoryDataRead, v.exp_data);
    check({v.name, " err"}, {31'b0, memoryError}, {31'b0, v.exp_err});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Stimulus table: one record per clock cycle, expected outputs after that edge.
    vecs.push_back(mk("st_w_10",   1, 0, 0, LW, 32'h10, 32'h80FF7F01, 32'h00000000, 0));
    vecs.push_back(mk("st_w_00",   1, 0, 0, LW, 32'h00, 32'h0BADF00D, 32'h00000000, 0));
    vecs.push_back(mk("st_w_44",   1, 0, 0, LW, 32'h44, 32'h13579BDF, 32'h00000000, 0));
    vecs.push_back(mk("ld_bs_11",  0, 1, 0, LB, 32'h11, 32'h0,        32'h0000007F, 0));
    vecs.push_back(mk("ld_bs_13",  0, 1, 0, LB, 32'h13, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk("ld_bu_13",  0, 1, 1, LB, 32'h13, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk("ld_bs_12",  0, 1, 0, LB, 32'h12, 32'h0,        32'hFFFFFFFF, 0));
    vecs.push_back(mk("ld_hu_12",  0, 1, 1, LH, 32'h12, 32'h0,        32'h000080FF, 0));
    vecs.push_back(mk("ld_hs_10",  0, 1, 0, LH, 32'h10, 32'h0,        32'h00007F01, 0));
    vecs.push_back(mk("st_w_20",   1, 0, 0, LW, 32'h20, 32'h11223344, 32'h00007F01, 0));
    vecs.push_back(mk("st_h_22",   1, 0, 0, LH, 32'h22, 32'hDEADBEEF, 32'h00007F01, 0));
    vecs.push_back(mk("ld_w_20",   0, 1, 0, LW, 32'h20, 32'h0,        32'hBEEF3344, 0));
    vecs.push_back(mk("ld_hs_22",  0, 1, 0, LH, 32'h22, 32'h0,        32'hFFFFBEEF, 0));
    vecs.push_back(mk("st_b_21",   1, 0, 0, LB, 32'h21, 32'h123456A5, 32'hFFFFBEEF, 0));
    vecs.push_back(mk("ld_w_20b",  0, 1, 0, LW, 32'h20, 32'h0,        32'hBEEFA544, 0));
    vecs.push_back(mk("idle",      0, 0, 1, LB, 32'h13, 32'hFFFFFFFF, 32'hBEEFA544, 0));
    vecs.push_back(mk("st_w_30",   1, 0, 0, LW, 32'h30, 32'hCAFEF00D, 32'hBEEFA544, 0));
    vecs.push_back(mk("ld_w_30",   0, 1, 0, LW, 32'h30, 32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk("ld_bu_30",  0, 1, 1, LB, 32'h30, 32'h0,        32'h0000000D, 0));
    vecs.push_back(mk("ld_hs_32",  0, 1, 0, LH, 32'h32, 32'h0,        32'hFFFFCAFE, 0));
    vecs.push_back(mk("ld_wu_00",  0, 1, 1, LW, 32'h00, 32'h0,        32'h0BADF00D, 0));

    drive(mk("rst", 0, 0, 0, LB, 32'h0, 32'h0, 32'h0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset data", memoryDataRead, 32'h0);
    check("reset err", {31'b0, memoryError}, 32'h0);
    check("reset err_addr", errorAddress, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // Load at one edge, then three idle cycles: data changes only at the load edge.
    drive(mk("hold_ld", 0, 1, 0, LW, 32'h10, 32'h0, 32'h0, 0));
    check("hold pre-edge", memoryDataRead, 32'h0BADF00D);
    @(posedge clk);
    #1;
    check("hold load edge", memoryDataRead, 32'h80FF7F01);
    @(negedge clk);
    apply(mk("hold_idle1", 0, 0, 0, LH, 32'h20, 32'h12345678, 32'h80FF7F01, 0));
    apply(mk("hold_idle2", 0, 0, 1, LB, 32'h30, 32'hFFFFFFFF, 32'h80FF7F01, 0));
    apply(mk("hold_idle3", 0, 0, 0, LR, 32'h1000, 32'h0,      32'h80FF7F01, 0));

    // Misaligned accesses: aligned down by default, errors when the check is enabled.
    apply(mk("mis_pre",   0, 1, 0, LW, 32'h30, 32'h0, 32'hCAFEF00D, 0));
    apply(mk("mis_ld_w",  0, 1, 0, LW, 32'h12, 32'h0, MIS ? 32'h0 : 32'h80FF7F01, MIS));
    check("mis err_addr", errorAddress, MIS ? 32'h12 : 32'h0);
    apply(mk("mis_ld_h",  0, 1, 0, LH, 32'h13, 32'h0, MIS ? 32'h0 : 32'hFFFF80FF, MIS));
    apply(mk("mis_st_h",  1, 0, 0, LH, 32'h11, 32'h00007777, MIS ? 32'h0 : 32'hFFFF80FF, MIS));
    apply(mk("mis_chk",   0, 1, 0, LW, 32'h10, 32'h0, MIS ? 32'h80FF7F01 : 32'h80FF7777, MIS));

    // Reset one cycle after a load: output and flags cleared, requests ignored, RAM kept.
    apply(mk("rst_ld", 0, 1, 0, LW, 32'h20, 32'h0, 32'hBEEFA544, MIS));
    reset = 1'b0;
    drive(mk("rst_req", 1, 1, 0, LW, 32'h20, 32'hFFFFFFFF, 32'h0, 0));
    #1;
    check("rst async data", memoryDataRead, 32'h0);
    check("rst async err", {31'b0, memoryError}, 32'h0);
    check("rst async err_addr", errorAddress, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(mk("rst_rel_idle", 0, 0, 0, LB, 32'h0, 32'h0, 32'h0, 0));
    check("rst rel err_addr", errorAddress, 32'h0);
    apply(mk("rst_ram_20", 0, 1, 0, LW, 32'h20, 32'h0, 32'hBEEFA544, 0));
    apply(mk("rst_ram_00", 0, 1, 0, LW, 32'h00, 32'h0, 32'h0BADF00D, 0));

    // Error handling: load+store collision, out-of-range and reserved-length accesses.
    apply(mk("err_both",  1, 1, 0, LW, 32'h40, 32'h5A5A1234, 32'h0BADF00D, 1));
    check("err_both err_addr", errorAddress, 32'h40);
    apply(mk("err_oor_st", 1, 0, 0, LW, DEPTH * 4, 32'hDEAD0000, 32'h0BADF00D, 1));
    check("err_oor err_addr", errorAddress, 32'h40);
    apply(mk("err_oor_ld", 0, 1, 0, LW, DEPTH * 4, 32'h0, 32'h0,        1));
    apply(mk("err_alias",  0, 1, 0, LW, 32'h00,    32'h0, 32'h0BADF00D, 1));
    apply(mk("err_st_40",  0, 1, 0, LW, 32'h40,    32'h0, 32'h5A5A1234, 1));
    apply(mk("err_rsv_st", 1, 0, 0, LR, 32'h44,    32'h0, 32'h5A5A1234, 1));
    apply(mk("err_rsv_chk", 0, 1, 0, LW, 32'h44,   32'h0, 32'h13579BDF, 1));
    apply(mk("err_rsv_ld", 0, 1, 0, LR, 32'h44,    32'h0, 32'h0,        1));
    check("err final err_addr", errorAddress, 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
